// File: rtl/mat_stream_mac.sv
// rtl/mat_stream_mac.sv - streaming square matrix multiply C = A x B with one MAC
//
// Purpose: accepts A then B (row-major) on one input stream, buffers both,
// computes each C element with a single multiply-accumulate and emits C
// row-major on the output stream, last on C[dim-1][dim-1].
//
// Ports:
//   axis_clk, axis_rst      clock, synchronous active-high reset
//   clk_en                  state advances only when high
//   cfg_dim, cfg_sat        dimension and saturate/wrap mode, latched at frame start
//   s_axis_*                input element stream (data/valid/last/ready)
//   m_axis_*                result element stream (data/valid/last/ready)
//   o_cfg_err               sticky: latched dimension was 0 or above N_MAX
//   o_frame_err             sticky: input last misplaced or missing
module mat_stream_mac #(
    parameter int DATA_W = 8,
    parameter int N_MAX  = 4,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 2 * DATA_W + $clog2(N_MAX) + 1
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,
    input  logic                     clk_en,
    input  logic [$clog2(N_MAX):0]   cfg_dim,
    input  logic                     cfg_sat,
    input  logic [DATA_W-1:0]        s_axis_data,
    input  logic                     s_axis_valid,
    input  logic                     s_axis_last,
    output logic                     s_axis_ready,
    output logic [OUT_W-1:0]         m_axis_data,
    output logic                     m_axis_valid,
    output logic                     m_axis_last,
    input  logic                     m_axis_ready,
    output logic                     o_cfg_err,
    output logic                     o_frame_err
);

    localparam int DIM_W = $clog2(N_MAX) + 1;
    localparam int IDX_W = $clog2(N_MAX * N_MAX);
    localparam int MUL_W = 2 * DIM_W;

    typedef enum logic [1:0] {S_LOAD_A, S_LOAD_B, S_MAC, S_OUT} state_t;

    state_t              state;
    logic [DIM_W-1:0]    dim;
    logic                sat;
    logic                dim_bad;
    logic [MUL_W-1:0]    idx;
    logic [DIM_W-1:0]    row;
    logic [DIM_W-1:0]    col;
    logic [DIM_W-1:0]    k;
    logic [ACC_W-1:0]    acc;

    logic [DATA_W-1:0]   a_buf [N_MAX*N_MAX];
    logic [DATA_W-1:0]   b_buf [N_MAX*N_MAX];

    logic                in_xfer;
    logic                cfg_bad;
    logic [MUL_W-1:0]    area_m1;
    logic [IDX_W-1:0]    a_addr;
    logic [IDX_W-1:0]    b_addr;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_next;
    logic [OUT_W-1:0]    out_val;

    assign in_xfer = s_axis_valid && s_axis_ready && clk_en;
    assign cfg_bad = (cfg_dim == '0) || (cfg_dim > DIM_W'(N_MAX));
    assign area_m1 = MUL_W'(dim) * MUL_W'(dim) - MUL_W'(1);

    // A[row][k] and B[k][col] in row-major buffers of the latched dimension.
    assign a_addr = IDX_W'(MUL_W'(row) * MUL_W'(dim) + MUL_W'(k));
    assign b_addr = IDX_W'(MUL_W'(k) * MUL_W'(dim) + MUL_W'(col));
    assign prod     = a_buf[a_addr] * b_buf[b_addr];
    assign acc_next = acc + ACC_W'(prod);

    // Saturation clamps only the presented value; the accumulator never overflows.
    assign out_val = (sat && (|acc_next[ACC_W-1:OUT_W])) ? '1 : acc_next[OUT_W-1:0];

    always_ff @(posedge axis_clk) begin
        if (in_xfer && state == S_LOAD_A) a_buf[idx[IDX_W-1:0]] <= s_axis_data;
        if (in_xfer && state == S_LOAD_B) b_buf[idx[IDX_W-1:0]] <= s_axis_data;
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state        <= S_LOAD_A;
            idx          <= '0;
            row          <= '0;
            col          <= '0;
            k            <= '0;
            acc          <= '0;
            s_axis_ready <= 1'b1;
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            m_axis_data  <= '0;
            o_cfg_err    <= 1'b0;
            o_frame_err  <= 1'b0;
            // Reset is itself a frame start; the error flag follows one enabled cycle later.
            dim          <= cfg_bad ? DIM_W'(N_MAX) : cfg_dim;
            sat          <= cfg_sat;
            dim_bad      <= cfg_bad;
        end else if (clk_en) begin
            if (dim_bad) o_cfg_err <= 1'b1;
            case (state)
                S_LOAD_A: begin
                    if (in_xfer) begin
                        if (s_axis_last) o_frame_err <= 1'b1;
                        if (idx == area_m1) begin
                            idx   <= '0;
                            state <= S_LOAD_B;
                        end else begin
                            idx <= idx + MUL_W'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (in_xfer) begin
                        if (idx == area_m1) begin
                            if (!s_axis_last) o_frame_err <= 1'b1;
                            idx          <= '0;
                            row          <= '0;
                            col          <= '0;
                            k            <= '0;
                            acc          <= '0;
                            s_axis_ready <= 1'b0;
                            state        <= S_MAC;
                        end else begin
                            if (s_axis_last) o_frame_err <= 1'b1;
                            idx <= idx + MUL_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (k == dim - DIM_W'(1)) begin
                        m_axis_data  <= out_val;
                        m_axis_last  <= (row == dim - DIM_W'(1)) && (col == dim - DIM_W'(1));
                        m_axis_valid <= 1'b1;
                        state        <= S_OUT;
                    end else begin
                        k <= k + DIM_W'(1);
                    end
                end
                S_OUT: begin
                    if (m_axis_ready) begin
                        m_axis_valid <= 1'b0;
                        acc          <= '0;
                        k            <= '0;
                        if (m_axis_last) begin
                            row          <= '0;
                            col          <= '0;
                            s_axis_ready <= 1'b1;
                            dim          <= cfg_bad ? DIM_W'(N_MAX) : cfg_dim;
                            sat          <= cfg_sat;
                            dim_bad      <= cfg_bad;
                            state        <= S_LOAD_A;
                        end else if (col == dim - DIM_W'(1)) begin
                            col   <= '0;
                            row   <= row + DIM_W'(1);
                            state <= S_MAC;
                        end else begin
                            col   <= col + DIM_W'(1);
                            state <= S_MAC;
                        end
                    end
                end
                default: state <= S_LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_stream_mac.sv
// tb/tb_mat_stream_mac.sv - directed self-checking bench for mat_stream_mac
module tb_mat_stream_mac;

    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b1;
    logic        clk_en = 1'b1;
    logic [2:0]  cfg_dim = 3'd2;
    logic        cfg_sat = 1'b1;
    logic [7:0]  s_axis_data = '0;
    logic        s_axis_valid = 1'b0;
    logic        s_axis_last = 1'b0;
    logic        s_axis_ready;
    logic [15:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_last;
    logic        m_axis_ready = 1'b1;
    logic        o_cfg_err;
    logic        o_frame_err;

    logic        toggle_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [7:0]  vec [32];
    logic [15:0] got_data [16];
    logic        got_last [16];
    int          got_n;
    int          held_bad;

    mat_stream_mac dut (
        .axis_clk     (axis_clk),
        .axis_rst     (axis_rst),
        .clk_en       (clk_en),
        .cfg_dim      (cfg_dim),
        .cfg_sat      (cfg_sat),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .o_cfg_err    (o_cfg_err),
        .o_frame_err  (o_frame_err)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) begin
        #1;
        clk_en = toggle_en ? ~clk_en : 1'b1;
    end

    task automatic do_reset(input logic [2:0] d, input logic s);
        @(negedge axis_clk);
        cfg_dim = d;
        cfg_sat = s;
        axis_rst = 1'b1;
        @(negedge axis_clk);
        axis_rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int t = 0;
        s_axis_data  = d;
        s_axis_valid = 1'b1;
        s_axis_last  = l;
        while (!(s_axis_ready && clk_en) && t < 200) begin
            @(negedge axis_clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: s_axis_ready=%0b after %0d cycles, required 1", s_axis_ready, t);
        end
        @(negedge axis_clk);
    endtask

    task automatic send(input int n, input int last_pos);
        for (int i = 0; i < n; i++) push(vec[i], i == last_pos);
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic recv(input int n, input int stall_idx, input int stall_cyc);
        int t = 0;
        logic stalled = 1'b0;
        logic [15:0] hold;
        got_n = 0;
        held_bad = 0;
        m_axis_ready = 1'b1;
        while (got_n < n && t < 3000) begin
            if (m_axis_valid && clk_en) begin
                if (got_n == stall_idx && !stalled) begin
                    stalled = 1'b1;
                    m_axis_ready = 1'b0;
                    hold = m_axis_data;
                    repeat (stall_cyc) begin
                        @(negedge axis_clk);
                        if (!m_axis_valid || m_axis_data !== hold) held_bad++;
                    end
                    m_axis_ready = 1'b1;
                    continue;
                end
                got_data[got_n] = m_axis_data;
                got_last[got_n] = m_axis_last;
                got_n++;
            end
            @(negedge axis_clk);
            t++;
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 8; i++) vec[i] = 8'(i + 1);
    endtask

    task automatic test_reset();
        do_reset(3'd2, 1'b1);
        n_checks++; if (s_axis_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %0b expected 1", s_axis_ready); end
        n_checks++; if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b expected 0", m_axis_valid); end
        n_checks++; if (m_axis_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %0b expected 0", m_axis_last); end
        n_checks++; if (m_axis_data !== 16'd0) begin n_fail++; $display("FAIL reset_m_data: got %0h expected 0", m_axis_data); end
        repeat (2) @(negedge axis_clk);
        n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %0b expected 0", o_cfg_err); end
        n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %0b expected 0", o_frame_err); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_c [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        load_basic();
        send(8, 7);
        n_checks++; if (s_axis_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %0b expected 0", s_axis_ready); end
        recv(4, -1, 0);
        n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_data[i] !== exp_c[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got_data[i], exp_c[i]); end
            n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d]: got %0b expected %0b", i, got_last[i], i == 3); end
        end
        n_checks++; if (s_axis_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back: got %0b expected 1", s_axis_ready); end
        n_checks++; if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %0b expected 0", m_axis_valid); end
        n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_frame_err: got %0b expected 0", o_frame_err); end
        n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL basic_cfg_err: got %0b expected 0", o_cfg_err); end
    endtask

    task automatic test_saturate();
        do_reset(3'd4, 1'b1);
        for (int i = 0; i < 32; i++) vec[i] = 8'hFF;
        send(32, 31);
        cfg_sat = 1'b0;
        recv(16, -1, 0);
        n_checks++; if (got_n !== 16) begin n_fail++; $display("FAIL sat_count: got %0d expected 16", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_data[i] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_data[%0d]: got %0h expected ffff", i, got_data[i]); end
            n_checks++; if (got_last[i] !== (i == 15)) begin n_fail++; $display("FAIL sat_last[%0d]: got %0b expected %0b", i, got_last[i], i == 15); end
        end
    endtask

    task automatic test_wrap();
        send(32, 31);
        recv(16, -1, 0);
        n_checks++; if (got_n !== 16) begin n_fail++; $display("FAIL wrap_count: got %0d expected 16", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_data[i] !== 16'hF804) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0h expected f804", i, got_data[i]); end
        end
        n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL wrap_frame_err: got %0b expected 0", o_frame_err); end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_c [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        do_reset(3'd2, 1'b1);
        load_basic();
        send(8, 7);
        recv(4, 1, 5);
        n_checks++; if (held_bad !== 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable stall cycles, expected 0", held_bad); end
        n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_data[i] !== exp_c[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, got_data[i], exp_c[i]); end
        end
    endtask

    task automatic test_clk_en();
        logic [15:0] exp_c [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        do_reset(3'd2, 1'b1);
        load_basic();
        toggle_en = 1'b1;
        send(8, 7);
        recv(4, -1, 0);
        toggle_en = 1'b0;
        n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL clken_count: got %0d expected 4", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_data[i] !== exp_c[i]) begin n_fail++; $display("FAIL clken_data[%0d]: got %0d expected %0d", i, got_data[i], exp_c[i]); end
            n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL clken_last[%0d]: got %0b expected %0b", i, got_last[i], i == 3); end
        end
        repeat (2) @(negedge axis_clk);
    endtask

    task automatic test_cfg_err();
        do_reset(3'd0, 1'b1);
        for (int i = 0; i < 16; i++) vec[i] = 8'd1;
        for (int i = 16; i < 32; i++) vec[i] = 8'(i - 16);
        send(32, 3);
        recv(16, -1, 0);
        n_checks++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_flag: got %0b expected 1", o_cfg_err); end
        n_checks++; if (o_frame_err !== 1'b1) begin n_fail++; $display("FAIL cfg_frame_err: got %0b expected 1", o_frame_err); end
        n_checks++; if (got_n !== 16) begin n_fail++; $display("FAIL cfg_count: got %0d expected 16", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_data[i] !== 16'(24 + 4 * (i % 4))) begin n_fail++; $display("FAIL cfg_data[%0d]: got %0d expected %0d", i, got_data[i], 24 + 4 * (i % 4)); end
        end
        n_checks++; if (got_last[15] !== 1'b1) begin n_fail++; $display("FAIL cfg_last: got %0b expected 1", got_last[15]); end
    endtask

    task automatic test_reset_mid_mac();
        logic [15:0] exp_c [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        do_reset(3'd2, 1'b1);
        repeat (2) @(negedge axis_clk);
        n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_err_clear: got %0b expected 0", o_cfg_err); end
        n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err_clear: got %0b expected 0", o_frame_err); end
        load_basic();
        send(8, 7);
        recv(1, -1, 0);
        n_checks++; if (got_data[0] !== 16'd19) begin n_fail++; $display("FAIL rst_first: got %0d expected 19", got_data[0]); end
        axis_rst = 1'b1;
        @(negedge axis_clk);
        axis_rst = 1'b0;
        n_checks++; if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %0b expected 0", m_axis_valid); end
        n_checks++; if (s_axis_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %0b expected 1", s_axis_ready); end
        n_checks++; if (m_axis_data !== 16'd0) begin n_fail++; $display("FAIL rst_mid_data: got %0d expected 0", m_axis_data); end
        repeat (4) @(negedge axis_clk);
        n_checks++; if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle_valid: got %0b expected 0", m_axis_valid); end
        send(8, 7);
        recv(4, -1, 0);
        n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL rst_count: got %0d expected 4", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++; if (got_data[i] !== exp_c[i]) begin n_fail++; $display("FAIL rst_data[%0d]: got %0d expected %0d", i, got_data[i], exp_c[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_wrap();
        test_backpressure();
        test_clk_en();
        test_cfg_err();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
